// File: rtl/lfu_arbiter_pkg.sv
// Shared types and default sizing for the least-frequently-used arbiter.
package lfu_pkg;

  localparam int N_REQ        = 4;
  localparam int CNT_W        = 8;
  localparam int HOLD_MAX_DEF = 16;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    RELEASE
  } state_t;

  typedef logic [N_REQ-1:0][CNT_W-1:0] cnt_arr_t;

endpackage

// File: rtl/lfu_arbiter_if.sv
// Request/grant bundle between the requester front end and the LFU arbiter.
interface lfu_arbiter_if
  import lfu_pkg::*;
#(
  parameter int N  = N_REQ,
  parameter int CW = CNT_W
);

  logic [N-1:0]         req;
  logic                 rel;
  logic [N-1:0]         gnt;
  logic                 busy;
  logic [$clog2(N)-1:0] owner;
  logic [N*CW-1:0]      count;
  logic                 forced;

  modport master (
    output req, rel,
    input  gnt, busy, owner, count, forced
  );

  modport slave (
    input  req, rel,
    output gnt, busy, owner, count, forced
  );

endinterface

// File: rtl/lfu_arbiter_min_select.sv
// Combinational argmin over the requesting counters; lowest index wins ties.
module lfu_min_select
  import lfu_pkg::*;
#(
  parameter int N  = N_REQ,
  parameter int CW = CNT_W
) (
  input  logic [N-1:0]          mask,
  input  logic [N-1:0][CW-1:0]  counts,
  output logic [$clog2(N)-1:0]  idx,
  output logic                  valid
);

  localparam int IW = $clog2(N);

  logic [CW-1:0] best;

  // Strict less-than keeps the earlier (lower) index on equal counts.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    best  = '1;
    for (int unsigned i = 0; i < N; i++) begin
      if (mask[i] && (!valid || counts[i] < best)) begin
        valid = 1'b1;
        idx   = IW'(i);
        best  = counts[i];
      end
    end
  end

endmodule

// File: rtl/lfu_arbiter.sv
// LFU arbiter: grants the least-used requester, halves all counters on saturation,
// and forces release after HOLD_MAX cycles of continuous ownership.
module lfu_arbiter
  import lfu_pkg::*;
#(
  parameter int N        = N_REQ,
  parameter int CW       = CNT_W,
  parameter int HOLD_MAX = HOLD_MAX_DEF
) (
  input  logic         clk,
  input  logic         rst,
  lfu_arbiter_if.slave bus
);

  localparam int IW = $clog2(N);
  localparam int HW = $clog2(HOLD_MAX);

  state_t                state;
  logic [N-1:0]          gnt_q;
  logic                  busy_q;
  logic [IW-1:0]         owner_q;
  logic [N-1:0][CW-1:0]  cnt_q;
  logic [N-1:0][CW-1:0]  cnt_nxt;
  logic [HW-1:0]         hold_q;
  logic                  forced_q;

  logic [IW-1:0]         win;
  logic                  win_valid;
  logic                  early_exit;
  logic                  timeout;

  lfu_min_select #(
    .N  (N),
    .CW (CW)
  ) u_sel (
    .mask   (bus.req),
    .counts (cnt_q),
    .idx    (win),
    .valid  (win_valid)
  );

  // Halve everything first when the winner is saturated, so the winner lands on 2^(CW-1).
  always_comb begin
    cnt_nxt = cnt_q;
    if (cnt_q[win] == '1) begin
      for (int unsigned i = 0; i < N; i++) begin
        cnt_nxt[i] = cnt_q[i] >> 1;
      end
    end
    cnt_nxt[win] = cnt_nxt[win] + CW'(1);
  end

  assign early_exit = bus.rel || !bus.req[owner_q];
  assign timeout    = (hold_q == HW'(HOLD_MAX - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      gnt_q    <= '0;
      busy_q   <= 1'b0;
      owner_q  <= '0;
      cnt_q    <= '0;
      hold_q   <= '0;
      forced_q <= 1'b0;
    end else begin
      forced_q <= 1'b0;
      case (state)
        IDLE: begin
          if (win_valid) begin
            state   <= GRANT;
            gnt_q   <= N'(1) << win;
            owner_q <= win;
            busy_q  <= 1'b1;
            hold_q  <= '0;
            cnt_q   <= cnt_nxt;
          end
        end
        GRANT: begin
          if (early_exit || timeout) begin
            state    <= RELEASE;
            gnt_q    <= '0;
            forced_q <= !early_exit;
          end else begin
            hold_q <= hold_q + HW'(1);
          end
        end
        RELEASE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          hold_q <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt    = gnt_q;
  assign bus.busy   = busy_q;
  assign bus.owner  = owner_q;
  assign bus.count  = cnt_q;
  assign bus.forced = forced_q;

endmodule
